iecdrv_head_ctrl: RTL and testbench
===================================

Name: iecdrv_head_ctrl

Overview:
Parametrised head-positioning and track-flush controller for the IEC drive family (1541/157x and later double-sided variants).
- Decodes the 2-bit stepper phase into a half-track position and adds the side offset to form the physical track index for the SD track loader.
- Tracks buffer modification and issues track-save requests over a req/ack handshake instead of a toggle.
- Triggers a save on step, on side change, or after a programmable idle delay.

Parameters:
SIDES, 2, number of disk sides (1 or 2); with 1 the side input is ignored
MAX_HT, 84, highest legal half-track index
START_HT, 36, half-track position after reset
SIDE_OFS, 84, track index offset added for side 1
TW, 8, width of track outputs
IDLE_DLY, 0, ce ticks of inactivity (dirty & ~write & ~act) before an idle flush; 0 = flush on first idle tick

Ports:
clk  in  1  drive clock
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable for idle counter
mtr  in  1  spindle motor on; stepping and step/side-triggered saves only while high
stp  in  2  stepper phase from drive logic
side  in  1  head select
write  in  1  write in progress
act  in  1  drive activity
sd_update  in  1  track buffer modified (one-cycle pulse)
img_mounted  in  1  image change; clears dirty
save_ack  in  1  loader accepted save request
track  out  TW  current physical track index (registered)
save_req  out  1  save request, held until ack
save_track  out  TW  track index to be saved, latched at request
dirty  out  1  buffer modified since last save launch
tr00  out  1  high when half-track position = 0
step_err  out  8  invalid-step counter (see Optional Feature)

Behaviour:
- Reset values: ht=START_HT; track=START_HT; save_req=0; save_track=0; dirty=0; tr00=(START_HT==0); idle counter=0; step_err=0; stp_old<=stp; side_old<=side.
- Step decode, every cycle: delta = (stp - stp_old) mod 4; stp_old<=stp always.
  - With mtr=1: delta 1 -> ht+1 if ht<MAX_HT, else hold; delta 3 -> ht-1 if ht>0, else hold; delta 2 = invalid, ht unchanged; delta 0 = no move.
  - With mtr=0: ht unchanged regardless of delta.
- track <= ht + ((SIDES==2 && side) ? SIDE_OFS : 0), one-cycle latency from ht/side change; width truncated to TW. tr00 registered likewise.
- side_old<=side every cycle. Side change = side!=side_old, counted only when SIDES==2 and mtr=1.
- Dirty:
  - set by sd_update; cleared by img_mounted.
  - img_mounted wins over sd_update in the same cycle.
  - Launching a save clears dirty unless sd_update arrives in the same cycle (set wins).
- Save trigger: dirty & ~save_req & (valid step with mtr | side change | idle timeout).
- On trigger:
  - save_req<=1.
  - save_track <= track value before the move/side change (the currently registered track output).
  - dirty cleared per the rule above.
- Handshake: save_req is held until save_ack is sampled high, then drops the next cycle. save_ack while save_req=0 is ignored.
- Triggers while save_req=1 are not queued; dirty stays set and relaunches on the next trigger after ack.
- Idle counter:
  - advances on ce while dirty & ~write & ~act & ~save_req.
  - clears whenever the condition is false.
  - timeout when count reaches IDLE_DLY; the counter then clears.
- Idle flush does not require mtr.
- Reset mid-request drops save_req immediately; the pending save is lost (the loader aborts on reset too).

Optional Feature:
IECDRV_HEAD_STEPERR_EN:
- Defined: step_err increments on each delta==2 while mtr=1, saturating at 255, cleared by reset.
- Not defined: step_err is tied to 0 and no counter logic is generated.

Test Plan:
- Reset, stp sequence 0,1,2,3,0 with mtr=1, side=0 -> track 36,37,38,39,40, one cycle after each phase.
- Step down from ht=1 with stp 1,0,3 -> ht 0 then held at 0, tr00=1; step up at MAX_HT=84 -> held at 84; side=1 -> track=168.
- sd_update pulse, then one up-step -> save_req=1, save_track=36, dirty=0; save_ack after 5 cycles -> save_req low next cycle.
- IDLE_DLY=10, sd_update then write=act=0 for 10 ce ticks -> save_req at tick 10; act pulse at tick 5 -> counter restarts, request at tick 15.
- sd_update and img_mounted in same cycle -> dirty=0, no save_req; sd_update coincident with a launch -> save_req=1 and dirty stays 1.
- With IECDRV_HEAD_STEPERR_EN, stp 0->2 x300 with mtr=1 -> ht unchanged, step_err=255; with mtr=0 -> step_err=0.

Source files
------------

// File: rtl/iecdrv_head_ctrl.sv
// Head positioning and track-flush controller: stepper decode, physical track index, save handshake.
// Optional step error counter enabled by defining IECDRV_HEAD_STEPERR_EN.
module iecdrv_head_ctrl #(
  parameter int unsigned SIDES    = 2,
  parameter int unsigned MAX_HT   = 84,
  parameter int unsigned START_HT = 36,
  parameter int unsigned SIDE_OFS = 84,
  parameter int unsigned TW       = 8,
  parameter int unsigned IDLE_DLY = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          mtr,
  input  logic [1:0]    stp,
  input  logic          side,
  input  logic          write,
  input  logic          act,
  input  logic          sd_update,
  input  logic          img_mounted,
  input  logic          save_ack,
  output logic [TW-1:0] track,
  output logic          save_req,
  output logic [TW-1:0] save_track,
  output logic          dirty,
  output logic          tr00,
  output logic [7:0]    step_err
);

  localparam int unsigned HW = (MAX_HT > 0) ? $clog2(MAX_HT + 1) : 1;
  localparam int unsigned CW = (IDLE_DLY > 1) ? $clog2(IDLE_DLY + 1) : 1;

  logic [HW-1:0] ht_q, ht_d;
  logic [1:0]    stp_q;
  logic          side_q;
  logic [1:0]    delta;
  logic          step_up, step_dn, side_chg;
  logic [TW-1:0] track_q, track_d;
  logic          tr00_q;
  logic          save_req_q, save_req_d;
  logic [TW-1:0] save_track_q, save_track_d;
  logic          dirty_q, dirty_d;
  logic [CW-1:0] idle_q, idle_d;
  logic          quiet, idle_hit, trigger;

  assign delta    = stp - stp_q;
  assign step_up  = mtr && (delta == 2'd1);
  assign step_dn  = mtr && (delta == 2'd3);
  assign side_chg = (SIDES == 2) && mtr && (side != side_q);

  always_comb begin
    ht_d = ht_q;
    if (step_up && (ht_q < HW'(MAX_HT))) begin
      ht_d = ht_q + 1'b1;
    end else if (step_dn && (ht_q != '0)) begin
      ht_d = ht_q - 1'b1;
    end
  end

  always_comb begin
    track_d = TW'(ht_q);
    if ((SIDES == 2) && side) begin
      track_d = TW'(ht_q) + TW'(SIDE_OFS);
    end
  end

  // Idle timer only runs while there is something to flush and no request outstanding.
  assign quiet    = dirty_q && !write && !act && !save_req_q;
  assign idle_hit = quiet && ce && ((32'(idle_q) + 32'd1) >= 32'(IDLE_DLY));

  always_comb begin
    idle_d = idle_q;
    if (!quiet || idle_hit) begin
      idle_d = '0;
    end else if (ce) begin
      idle_d = idle_q + 1'b1;
    end
  end

  assign trigger = dirty_q && !save_req_q && (step_up || step_dn || side_chg || idle_hit);

  always_comb begin
    save_req_d   = save_req_q;
    save_track_d = save_track_q;
    dirty_d      = dirty_q;
    if (save_req_q && save_ack) begin
      save_req_d = 1'b0;
    end else if (trigger) begin
      save_req_d = 1'b1;
    end
    // The registered track still reflects the position before this cycle's move.
    if (trigger) begin
      save_track_d = track_q;
    end
    if (img_mounted) begin
      dirty_d = 1'b0;
    end else if (sd_update) begin
      dirty_d = 1'b1;
    end else if (trigger) begin
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ht_q         <= HW'(START_HT);
      stp_q        <= stp;
      side_q       <= side;
      track_q      <= TW'(START_HT);
      tr00_q       <= (START_HT == 0);
      save_req_q   <= 1'b0;
      save_track_q <= '0;
      dirty_q      <= 1'b0;
      idle_q       <= '0;
    end else begin
      ht_q         <= ht_d;
      stp_q        <= stp;
      side_q       <= side;
      track_q      <= track_d;
      tr00_q       <= (ht_q == '0);
      save_req_q   <= save_req_d;
      save_track_q <= save_track_d;
      dirty_q      <= dirty_d;
      idle_q       <= idle_d;
    end
  end

  assign track      = track_q;
  assign tr00       = tr00_q;
  assign save_req   = save_req_q;
  assign save_track = save_track_q;
  assign dirty      = dirty_q;

`ifdef IECDRV_HEAD_STEPERR_EN
  logic [7:0] err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (mtr && (delta == 2'd2) && (err_q != 8'hff)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign step_err = err_q;
`else
  assign step_err = '0;
`endif

endmodule

// File: tb/tb_iecdrv_head_ctrl.sv
// Randomized bench for iecdrv_head_ctrl against a cycle-level behavioural model.
module tb_iecdrv_head_ctrl;

  localparam int SIDES    = 2;
  localparam int MAX_HT   = 84;
  localparam int START_HT = 36;
  localparam int SIDE_OFS = 84;
  localparam int TW       = 8;
  localparam int IDLE_DLY = 10;

  logic          clk = 1'b0;
  logic          reset, ce, mtr, side, write, act, sd_update, img_mounted, save_ack;
  logic [1:0]    stp;
  logic [TW-1:0] track, save_track;
  logic          save_req, dirty, tr00;
  logic [7:0]    step_err;

  iecdrv_head_ctrl #(
    .SIDES(SIDES), .MAX_HT(MAX_HT), .START_HT(START_HT),
    .SIDE_OFS(SIDE_OFS), .TW(TW), .IDLE_DLY(IDLE_DLY)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .mtr(mtr), .stp(stp), .side(side),
    .write(write), .act(act), .sd_update(sd_update), .img_mounted(img_mounted),
    .save_ack(save_ack), .track(track), .save_req(save_req), .save_track(save_track),
    .dirty(dirty), .tr00(tr00), .step_err(step_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int m_ht, m_track, m_tr00, m_req, m_strack, m_dirty, m_run, m_err;
  int stp_prev, side_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int d, ofs;
    bit moved, sch, quiet, timeout, fire;
    if (reset) begin
      m_ht = START_HT; m_track = START_HT % (1 << TW); m_tr00 = (START_HT == 0) ? 1 : 0;
      m_req = 0; m_strack = 0; m_dirty = 0; m_run = 0; m_err = 0;
    end else begin
      d       = (int'(stp) - stp_prev + 4) % 4;
      moved   = mtr && (d == 1 || d == 3);
      sch     = (SIDES == 2) && mtr && (int'(side) != side_prev);
      quiet   = (m_dirty != 0) && !write && !act && (m_req == 0);
      timeout = 0;
      if (!quiet) m_run = 0;
      else if (ce) begin
        m_run++;
        if (m_run >= ((IDLE_DLY == 0) ? 1 : IDLE_DLY)) begin
          timeout = 1;
          m_run   = 0;
        end
      end
      fire = (m_dirty != 0) && (m_req == 0) && (moved || sch || timeout);
      ofs  = (SIDES == 2 && side) ? SIDE_OFS : 0;
      if (fire) m_strack = m_track;
      m_track = (m_ht + ofs) % (1 << TW);
      m_tr00  = (m_ht == 0) ? 1 : 0;
      if (mtr && d == 1 && m_ht < MAX_HT) m_ht++;
      else if (mtr && d == 3 && m_ht > 0) m_ht--;
      if (m_req != 0 && save_ack) m_req = 0;
      else if (fire) m_req = 1;
      if (img_mounted) m_dirty = 0;
      else if (sd_update) m_dirty = 1;
      else if (fire) m_dirty = 0;
      if (mtr && d == 2 && m_err < 255) m_err++;
    end
    stp_prev  = int'(stp);
    side_prev = int'(side);
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("track", 32'(track), m_track);
    check("tr00", 32'(tr00), m_tr00);
    check("save_req", 32'(save_req), m_req);
    check("save_track", 32'(save_track), m_strack);
    check("dirty", 32'(dirty), m_dirty);
`ifdef IECDRV_HEAD_STEPERR_EN
    check("step_err", 32'(step_err), m_err);
`else
    check("step_err", 32'(step_err), 0);
`endif
  endtask

  task automatic quiet_inputs();
    ce = 1'b0; write = 1'b0; act = 1'b0; sd_update = 1'b0;
    img_mounted = 1'b0; save_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
  endtask

  // bias: 0 balanced, 1 mostly stepping down, 2 mostly stepping up
  task automatic drive_random(input int bias, input bit allow_reset);
    int r, up_p, dn_p;
    up_p = (bias == 2) ? 30 : (bias == 1) ? 8 : 20;
    dn_p = (bias == 1) ? 30 : (bias == 2) ? 8 : 20;
    r = int'($urandom_range(99));
    if (r < up_p) stp = stp + 2'd1;
    else if (r < up_p + dn_p) stp = stp - 2'd1;
    else if (r < up_p + dn_p + 3) stp = stp + 2'd2;
    mtr         = ($urandom_range(99) < 90);
    if ($urandom_range(99) < 3) side = ~side;
    sd_update   = ($urandom_range(99) < 8);
    img_mounted = ($urandom_range(99) < 2);
    save_ack    = ($urandom_range(99) < 25);
    write       = ($urandom_range(99) < 15);
    act         = ($urandom_range(99) < 15);
    ce          = ($urandom_range(99) < 70);
    reset       = allow_reset && ($urandom_range(999) < 5);
  endtask

  initial begin
    quiet_inputs();
    mtr = 1'b1; side = 1'b0; stp = 2'd0;
    stp_prev = 0; side_prev = 0;
    reset = 1'b1;
    step_cycle();
    step_cycle();
    reset = 1'b0;

    // Four up-steps from the reset position
    for (int i = 1; i <= 4; i++) begin
      stp = 2'(i);
      step_cycle();
    end
    step_cycle();

    // Idle flush, then restart of the idle count by an act pulse
    sd_update = 1'b1; step_cycle(); sd_update = 1'b0;
    ce = 1'b1;
    for (int i = 0; i < 14; i++) step_cycle();
    save_ack = 1'b1; step_cycle(); save_ack = 1'b0;
    sd_update = 1'b1; step_cycle(); sd_update = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      act = (i == 5);
      step_cycle();
    end
    act = 1'b0; save_ack = 1'b1; step_cycle(); save_ack = 1'b0; ce = 1'b0;

    // sd_update with img_mounted: nothing to save
    sd_update = 1'b1; img_mounted = 1'b1; step_cycle();
    sd_update = 1'b0; img_mounted = 1'b0;
    stp = stp + 2'd1; step_cycle();
    // sd_update coincident with a step launch keeps dirty set
    sd_update = 1'b1; step_cycle();
    stp = stp + 2'd1; step_cycle();
    sd_update = 1'b0;
    for (int i = 0; i < 5; i++) step_cycle();
    save_ack = 1'b1; step_cycle(); save_ack = 1'b0;
    step_cycle();

    // Side switch, then invalid steps saturating the error counter
    side = 1'b1; step_cycle(); step_cycle();
    side = 1'b0; do_reset();
    for (int i = 0; i < 300; i++) begin
      stp = 2'd2; step_cycle();
      stp = 2'd0; step_cycle();
    end
    mtr = 1'b0; do_reset();
    for (int i = 0; i < 20; i++) begin
      stp = stp + 2'd2; step_cycle();
    end
    mtr = 1'b1;

    // Random walks pushing into both end stops, then free mix with resets
    for (int i = 0; i < 3000; i++) begin drive_random(1, 1'b0); step_cycle(); end
    for (int i = 0; i < 3000; i++) begin drive_random(2, 1'b0); step_cycle(); end
    for (int i = 0; i < 3000; i++) begin drive_random(0, 1'b1); step_cycle(); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
